// File: rtl/serv_wakeup_timer_if.sv
// Single-cycle Wishbone slave bus that software uses to reach the wakeup timer.
// The master drives the request side and the slave answers with ack and read data.
interface serv_wakeup_timer_if;
   logic [1:0]  adr;
   logic [31:0] dat;
   logic        we;
   logic        cyc;
   logic [31:0] rdt;
   logic        ack;

   modport master (output adr, dat, we, cyc, input rdt, ack);
   modport slave  (input adr, dat, we, cyc, output rdt, ack);
endinterface

// File: rtl/serv_wakeup_timer.sv
// Always-on machine timer: a prescaled mtime counter is compared against mtimecmp,
// and a match latches a sticky pending flag that drives the wakeup interrupt.
module serv_wakeup_timer #(
   parameter int WIDTH          = 32,
   parameter int PRESCALE       = 1,
   parameter     RESET_STRATEGY = "MINI"
) (
   input  logic                i_clk,
   input  logic                i_rst,
   serv_wakeup_timer_if.slave  wb,
   output logic                o_timer_irq
);

   localparam int            PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PLAST     = PW'(PRESCALE - 1);
   localparam bit            RESET_ALL = (RESET_STRATEGY != "NONE");

   localparam logic [1:0] ADR_MTIME    = 2'd0;
   localparam logic [1:0] ADR_MTIMECMP = 2'd1;
   localparam logic [1:0] ADR_CTRL     = 2'd2;
   localparam logic [1:0] ADR_STATUS   = 2'd3;

   logic [WIDTH-1:0] mtime;
   logic [WIDTH-1:0] mtimecmp;
   logic [WIDTH-1:0] mtime_inc;
   logic [WIDTH-1:0] wdat;
   logic [1:0]       ctrl;
   logic             pending;
   logic [PW-1:0]    pcnt;
   logic             ack;
   logic [31:0]      rdt;
   logic [31:0]      rd_mux;

   logic access;
   logic wr_mtime;
   logic wr_cmp;
   logic wr_ctrl;
   logic clr_pending;
   logic tick;
   logic match;
   logic unused_dat;

   // An access is taken only while no ack is outstanding, giving one access per two cycles.
   assign access      = wb.cyc & ~ack;
   assign wr_mtime    = access & wb.we & (wb.adr == ADR_MTIME);
   assign wr_cmp      = access & wb.we & (wb.adr == ADR_MTIMECMP);
   assign wr_ctrl     = access & wb.we & (wb.adr == ADR_CTRL);
   assign clr_pending = access & wb.we & (wb.adr == ADR_STATUS) & wb.dat[0];
   assign wdat        = wb.dat[WIDTH-1:0];
   assign unused_dat  = ^wb.dat;

   assign tick      = ctrl[0] & (pcnt == PLAST);
   assign mtime_inc = mtime + WIDTH'(1);
   // Only a counting step can raise a match; a software write to MTIME suppresses it.
   assign match     = tick & ~wr_mtime & (mtime_inc == mtimecmp);

   always_comb begin
      rd_mux = '0;
      case (wb.adr)
         ADR_MTIME:    rd_mux = 32'(mtime);
         ADR_MTIMECMP: rd_mux = 32'(mtimecmp);
         ADR_CTRL:     rd_mux = {30'd0, ctrl};
         default:      rd_mux = {31'd0, pending};
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         if (RESET_ALL) pcnt <= '0;
      end else if (!ctrl[0] || tick) begin
         pcnt <= '0;
      end else begin
         pcnt <= pcnt + PW'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         if (RESET_ALL) mtime <= '0;
      end else if (wr_mtime) begin
         mtime <= wdat;
      end else if (tick) begin
         mtime <= mtime_inc;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         if (RESET_ALL) mtimecmp <= '1;
      end else if (wr_cmp) begin
         mtimecmp <= wdat;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         ctrl <= 2'b00;
      end else if (wr_ctrl) begin
         ctrl <= wb.dat[1:0];
      end
   end

   // Setting wins over a simultaneous write-one-to-clear.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         pending <= 1'b0;
      end else if (match) begin
         pending <= 1'b1;
      end else if (clr_pending) begin
         pending <= 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         ack <= 1'b0;
      end else begin
         ack <= access;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         if (RESET_ALL) rdt <= '0;
      end else if (access) begin
         rdt <= rd_mux;
      end
   end

   assign wb.ack      = ack;
   assign wb.rdt      = rdt;
   assign o_timer_irq = pending & ctrl[1];

endmodule

// File: tb/tb_serv_wakeup_timer.sv
// Bench for serv_wakeup_timer: directed scenarios on a 32-bit/prescale-4 and an
// 8-bit/prescale-1 instance, plus random bus traffic against a behavioural model.
module tb_serv_wakeup_timer;

   localparam int PRE_A = 4;

   logic clk = 1'b0;
   logic rst;
   logic irq_a;
   logic irq_b;
   logic [31:0] junk;
   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   serv_wakeup_timer_if bus_a();
   serv_wakeup_timer_if bus_b();

   serv_wakeup_timer #(.WIDTH(32), .PRESCALE(PRE_A), .RESET_STRATEGY("MINI")) dut_a (
      .i_clk(clk), .i_rst(rst), .wb(bus_a), .o_timer_irq(irq_a));

   serv_wakeup_timer #(.WIDTH(8), .PRESCALE(1), .RESET_STRATEGY("MINI")) dut_b (
      .i_clk(clk), .i_rst(rst), .wb(bus_b), .o_timer_irq(irq_b));

   // Reference model of instance A: mtime advances once every PRE_A enabled cycles.
   logic [31:0] m_time, m_cmp, m_rdt;
   logic        m_en, m_ie, m_pend, m_ack;
   int unsigned m_run;
   logic        m_acc, m_tick;

   assign m_acc  = bus_a.cyc & ~m_ack;
   assign m_tick = m_en && ((m_run % PRE_A) == PRE_A - 1);

   always @(posedge clk) begin
      if (rst) begin
         m_time <= 32'd0; m_cmp <= 32'hFFFF_FFFF; m_rdt <= 32'd0;
         m_en <= 1'b0; m_ie <= 1'b0; m_pend <= 1'b0; m_ack <= 1'b0; m_run <= 0;
      end else begin
         m_ack <= m_acc;
         m_run <= m_en ? m_run + 1 : 0;
         if (m_acc) begin
            case (bus_a.adr)
               2'd0:    m_rdt <= m_time;
               2'd1:    m_rdt <= m_cmp;
               2'd2:    m_rdt <= {30'd0, m_ie, m_en};
               default: m_rdt <= {31'd0, m_pend};
            endcase
         end
         if (m_acc && bus_a.we && bus_a.adr == 2'd0) m_time <= bus_a.dat;
         else if (m_tick) m_time <= m_time + 32'd1;
         if (m_acc && bus_a.we && bus_a.adr == 2'd1) m_cmp <= bus_a.dat;
         if (m_acc && bus_a.we && bus_a.adr == 2'd2) begin
            m_en <= bus_a.dat[0];
            m_ie <= bus_a.dat[1];
         end
         if (m_tick && !(m_acc && bus_a.we && bus_a.adr == 2'd0) && (m_time + 32'd1 == m_cmp))
            m_pend <= 1'b1;
         else if (m_acc && bus_a.we && bus_a.adr == 2'd3 && bus_a.dat[0])
            m_pend <= 1'b0;
      end
   end

   // Returns #1 after the accepting edge, with ack high and read data valid.
   task automatic wb_a(input logic [1:0] adr, input logic we, input logic [31:0] dat,
                       output logic [31:0] rdt);
      if (bus_a.ack) begin @(posedge clk); #1; end
      bus_a.cyc = 1'b1; bus_a.adr = adr; bus_a.we = we; bus_a.dat = dat;
      @(posedge clk); #1;
      bus_a.cyc = 1'b0; bus_a.we = 1'b0;
      rdt = bus_a.rdt;
   endtask

   task automatic wb_b(input logic [1:0] adr, input logic we, input logic [31:0] dat,
                       output logic [31:0] rdt);
      if (bus_b.ack) begin @(posedge clk); #1; end
      bus_b.cyc = 1'b1; bus_b.adr = adr; bus_b.we = we; bus_b.dat = dat;
      @(posedge clk); #1;
      bus_b.cyc = 1'b0; bus_b.we = 1'b0;
      rdt = bus_b.rdt;
   endtask

   task automatic test_reset();
      logic [31:0] rd;
      logic [31:0] exp_rd [4];
      exp_rd[0] = 32'd0; exp_rd[1] = 32'hFFFF_FFFF; exp_rd[2] = 32'd0; exp_rd[3] = 32'd0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if (irq_a !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_irq_in_reset: got %b want 0", irq_a); end
      rst = 1'b0;
      n_cmp++;
      if (bus_a.ack !== 1'b0 || bus_a.rdt !== 32'd0) begin
         n_bad++; $display("[TB] FAIL reset_bus: ack %b rdt %h want 0 0", bus_a.ack, bus_a.rdt);
      end
      for (int i = 0; i < 4; i++) begin
         wb_a(2'(i), 1'b0, 32'd0, rd);
         n_cmp++;
         if (rd !== exp_rd[i]) begin n_bad++; $display("[TB] FAIL reset_read%0d: got %h want %h", i, rd, exp_rd[i]); end
         n_cmp++;
         if (irq_a !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_irq%0d: got %b want 0", i, irq_a); end
      end
      wb_b(2'd1, 1'b0, 32'd0, rd);
      n_cmp++;
      if (rd !== 32'h0000_00FF) begin n_bad++; $display("[TB] FAIL reset_cmp_w8: got %h want 000000ff", rd); end
   endtask

   task automatic test_prescale();
      logic [31:0] rd;
      int n;
      wb_a(2'd1, 1'b1, 32'd3, rd);
      wb_a(2'd0, 1'b1, 32'd0, rd);
      wb_a(2'd2, 1'b1, 32'd3, rd);
      n = 0;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk); #1;
         if (irq_a) begin n = c; break; end
      end
      n_cmp++;
      if (n != 12) begin n_bad++; $display("[TB] FAIL prescale_latency: got %0d want 12 (0 = timeout)", n); end
      wb_a(2'd0, 1'b0, 32'd0, rd);
      n_cmp++;
      if (rd !== 32'd3) begin n_bad++; $display("[TB] FAIL prescale_mtime: got %h want 3", rd); end
   endtask

   task automatic test_irq_clear();
      logic [31:0] rd;
      wb_a(2'd3, 1'b1, 32'd0, rd);
      n_cmp++;
      if (irq_a !== 1'b1) begin n_bad++; $display("[TB] FAIL w0_no_effect: irq %b want 1", irq_a); end
      wb_a(2'd2, 1'b1, 32'd1, rd);
      n_cmp++;
      if (irq_a !== 1'b0) begin n_bad++; $display("[TB] FAIL ie_off_irq: irq %b want 0", irq_a); end
      wb_a(2'd3, 1'b0, 32'd0, rd);
      n_cmp++;
      if (rd !== 32'd1) begin n_bad++; $display("[TB] FAIL ie_off_keeps_pending: got %h want 1", rd); end
      wb_a(2'd2, 1'b1, 32'd3, rd);
      n_cmp++;
      if (irq_a !== 1'b1) begin n_bad++; $display("[TB] FAIL ie_on_irq: irq %b want 1", irq_a); end
      wb_a(2'd3, 1'b1, 32'd1, rd);
      n_cmp++;
      if (irq_a !== 1'b0) begin n_bad++; $display("[TB] FAIL w1c_irq: irq %b want 0", irq_a); end
   endtask

   // Arms a match that lands on the 4th edge after EN, then issues op on that edge.
   task automatic arm_and_hit(input logic [31:0] start, input logic [1:0] adr,
                              input logic [31:0] dat);
      logic [31:0] rd;
      wb_a(2'd2, 1'b1, 32'd0, rd);
      wb_a(2'd3, 1'b1, 32'd1, rd);
      wb_a(2'd0, 1'b1, start, rd);
      wb_a(2'd1, 1'b1, start + 32'd1, rd);
      wb_a(2'd2, 1'b1, 32'd1, rd);
      repeat (3) begin @(posedge clk); #1; end
      wb_a(adr, 1'b1, dat, rd);
   endtask

   task automatic test_coincide();
      logic [31:0] rd;
      arm_and_hit(32'd10, 2'd3, 32'd1);
      wb_a(2'd3, 1'b0, 32'd0, rd);
      n_cmp++;
      if (rd !== 32'd1) begin n_bad++; $display("[TB] FAIL w1c_vs_match: pending %h want 1", rd); end
      arm_and_hit(32'd20, 2'd0, 32'h55);
      wb_a(2'd0, 1'b0, 32'd0, rd);
      n_cmp++;
      if (rd !== 32'h55) begin n_bad++; $display("[TB] FAIL mtime_write_on_tick: got %h want 55", rd); end
      wb_a(2'd3, 1'b0, 32'd0, rd);
      n_cmp++;
      if (rd !== 32'd0) begin n_bad++; $display("[TB] FAIL mtime_write_no_match: pending %h want 0", rd); end
      arm_and_hit(32'd30, 2'd1, 32'd99);
      wb_a(2'd3, 1'b0, 32'd0, rd);
      n_cmp++;
      if (rd !== 32'd1) begin n_bad++; $display("[TB] FAIL cmp_write_old_match: pending %h want 1", rd); end
   endtask

   task automatic test_wrap();
      logic [31:0] rd;
      logic [7:0]  s, c;
      int k, n;
      for (int it = 0; it < 4; it++) begin
         s = (it == 0) ? 8'hFF : 8'($urandom);
         k = (it == 0) ? 1 : int'($urandom_range(1, 8));
         c = s + 8'(k);
         wb_b(2'd2, 1'b1, 32'd0, rd);
         wb_b(2'd3, 1'b1, 32'd1, rd);
         wb_b(2'd0, 1'b1, {24'd0, s}, rd);
         wb_b(2'd1, 1'b1, {24'd0, c}, rd);
         wb_b(2'd2, 1'b1, 32'd3, rd);
         n = 0;
         for (int cy = 1; cy <= 20; cy++) begin
            @(posedge clk); #1;
            if (irq_b) begin n = cy; break; end
         end
         n_cmp++;
         if (n != k) begin n_bad++; $display("[TB] FAIL wrap_match_s%h: latency %0d want %0d", s, n, k); end
         wb_b(2'd2, 1'b1, 32'd2, rd);
         wb_b(2'd3, 1'b1, 32'd1, rd);
         wb_b(2'd0, 1'b0, 32'd0, rd);
         n_cmp++;
         if (rd !== {24'd0, 8'(c + 8'd1)}) begin
            n_bad++; $display("[TB] FAIL wrap_mtime: got %h want %h", rd, {24'd0, 8'(c + 8'd1)});
         end
         wb_b(2'd1, 1'b1, rd, junk);
         repeat (3) begin @(posedge clk); #1; end
         wb_b(2'd3, 1'b0, 32'd0, rd);
         n_cmp++;
         if (rd !== 32'd0 || irq_b !== 1'b0) begin
            n_bad++; $display("[TB] FAIL equal_write_no_set: pending %h irq %b want 0 0", rd, irq_b);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd;
      @(posedge clk); #1;
      bus_a.cyc = 1'b1; bus_a.adr = 2'd2; bus_a.we = 1'b0;
      for (int i = 0; i < 6; i++) begin
         n_cmp++;
         if (bus_a.ack !== 1'(i % 2)) begin
            n_bad++; $display("[TB] FAIL ack_pattern%0d: got %b want %0d", i, bus_a.ack, i % 2);
         end
         @(posedge clk); #1;
      end
      bus_a.cyc = 1'b0;
      wb_a(2'd1, 1'b1, 32'hABCD, rd);
      wb_a(2'd1, 1'b0, 32'd0, rd);
      n_cmp++;
      if (rd !== 32'hABCD) begin n_bad++; $display("[TB] FAIL cmp_write: got %h want abcd", rd); end
      @(posedge clk); #1;
      bus_a.cyc = 1'b1; bus_a.adr = 2'd1; bus_a.we = 1'b1; bus_a.dat = 32'h1234; rst = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if (bus_a.ack !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_mid_ack: got %b want 0", bus_a.ack); end
      rst = 1'b0; bus_a.cyc = 1'b0; bus_a.we = 1'b0;
      wb_a(2'd1, 1'b0, 32'd0, rd);
      n_cmp++;
      if (rd !== 32'hFFFF_FFFF) begin n_bad++; $display("[TB] FAIL reset_mid_write: got %h want ffffffff", rd); end
   endtask

   task automatic test_random();
      for (int cy = 0; cy < 600; cy++) begin
         bus_a.cyc = ($urandom_range(0, 3) != 0);
         bus_a.adr = 2'($urandom);
         bus_a.we  = 1'($urandom_range(0, 1));
         case (bus_a.adr)
            2'd0, 2'd1: bus_a.dat = ($urandom_range(0, 1) != 0) ? m_time + $urandom_range(0, 12) : $urandom;
            2'd2: begin
               bus_a.dat = $urandom;
               if ($urandom_range(0, 3) != 0) bus_a.dat[0] = 1'b1;
            end
            default: bus_a.dat = $urandom;
         endcase
         @(posedge clk); #1;
         n_cmp++;
         if (bus_a.ack !== m_ack) begin n_bad++; $display("[TB] FAIL rand_ack@%0d: got %b want %b", cy, bus_a.ack, m_ack); end
         if (m_ack) begin
            n_cmp++;
            if (bus_a.rdt !== m_rdt) begin n_bad++; $display("[TB] FAIL rand_rdt@%0d: got %h want %h", cy, bus_a.rdt, m_rdt); end
         end
         n_cmp++;
         if (irq_a !== (m_pend & m_ie)) begin
            n_bad++; $display("[TB] FAIL rand_irq@%0d: got %b want %b", cy, irq_a, m_pend & m_ie);
         end
      end
      bus_a.cyc = 1'b0; bus_a.we = 1'b0;
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      rst = 1'b1;
      bus_a.cyc = 1'b0; bus_a.we = 1'b0; bus_a.adr = 2'd0; bus_a.dat = 32'd0;
      bus_b.cyc = 1'b0; bus_b.we = 1'b0; bus_b.adr = 2'd0; bus_b.dat = 32'd0;
      test_reset();
      test_prescale();
      test_irq_clear();
      test_coincide();
      test_wrap();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
